// File: rtl/wakeup_bcast_pkg.sv
// Shared widths, wheel entry type and bus-slicing helpers for the wakeup broadcaster.
// Pure declarations: no latency, no backpressure.
package wakeup_bcast_pkg;

    localparam int WIDTH_REG = 5;
    localparam int WIDTH_BRM = 3;
    localparam int MAX_LAT   = 4;
    localparam int WIDTH_LAT = 2;
    localparam int NUM_PORTS = 4;
    localparam int NUM_BRM   = 2 ** WIDTH_BRM;

    typedef struct packed {
        logic                 vld;
        logic [WIDTH_REG-1:0] rd;
        logic [WIDTH_BRM-1:0] brm;
    } wheel_ent_t;

    function automatic logic killf(input logic [NUM_BRM-1:0] brkill,
                                   input logic [WIDTH_BRM-1:0] brm);
        return brkill[brm];
    endfunction

    function automatic logic [WIDTH_REG-1:0] get_rd(input logic [NUM_PORTS*WIDTH_REG-1:0] bus,
                                                    input int p);
        return bus[p*WIDTH_REG +: WIDTH_REG];
    endfunction

    function automatic logic [WIDTH_LAT-1:0] get_lat(input logic [NUM_PORTS*WIDTH_LAT-1:0] bus,
                                                     input int p);
        return bus[p*WIDTH_LAT +: WIDTH_LAT];
    endfunction

    function automatic logic [WIDTH_BRM-1:0] get_brm(input logic [NUM_PORTS*WIDTH_BRM-1:0] bus,
                                                     input int p);
        return bus[p*WIDTH_BRM +: WIDTH_BRM];
    endfunction

endpackage

// File: rtl/wakeup_lane.sv
// Single-port timing wheel: holds one issued tag per stage and drives it on the lane L cycles later.
// Latency = encoded lat + 1 cycles; no backpressure, a colliding issue is dropped and flagged.
module wakeup_lane
    import wakeup_bcast_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 val,
    input  logic [WIDTH_REG-1:0] rd,
    input  logic [WIDTH_LAT-1:0] lat,
    input  logic [WIDTH_BRM-1:0] brm,
    input  logic [NUM_BRM-1:0]   brkill,
    output logic [WIDTH_REG-1:0] wdest,
    output logic [MAX_LAT-1:0]   busy,
    output logic                 conflict
);

    wheel_ent_t stg     [MAX_LAT];
    wheel_ent_t sh      [MAX_LAT];
    wheel_ent_t stg_nxt [MAX_LAT];
    logic       ins;
    logic       collide;
    logic       conflict_nxt;

    always_comb begin
        for (int k = 0; k < MAX_LAT; k++) begin
            sh[k]      = '0;
            stg_nxt[k] = '0;
        end
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            sh[k] = stg[k+1];
        end

        // A killed older entry yields its slot to the new issue.
        ins          = val && (rd != '0);
        collide      = sh[lat].vld && !killf(brkill, sh[lat].brm);
        conflict_nxt = ins && collide;

        for (int k = 0; k < MAX_LAT; k++) begin
            stg_nxt[k]     = sh[k];
            stg_nxt[k].vld = sh[k].vld && !killf(brkill, sh[k].brm);
        end
        if (ins && !collide) begin
            stg_nxt[lat].vld = !killf(brkill, brm);
            stg_nxt[lat].rd  = rd;
            stg_nxt[lat].brm = brm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                stg[k] <= '0;
            end
            conflict <= 1'b0;
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                stg[k] <= stg_nxt[k];
            end
            conflict <= conflict_nxt;
        end
    end

    // Busy reflects raw occupancy; a pending kill is not visible to select.
    always_comb begin
        busy = '0;
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            busy[k] = stg[k+1].vld;
        end
    end

    assign wdest = stg[0].vld ? stg[0].rd : '0;

endmodule

// File: rtl/wakeup_bcast.sv
// Four independent wakeup timing wheels packed onto the 4-lane destination-tag bus.
// Latency 1..MAX_LAT cycles per op; no backpressure, collisions drop the issue and pulse o_conflict.
module wakeup_bcast
    import wakeup_bcast_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_PORTS-1:0]           i_issue_val,
    input  logic [NUM_PORTS*WIDTH_REG-1:0] i_issue_rd,
    input  logic [NUM_PORTS*WIDTH_LAT-1:0] i_issue_lat,
    input  logic [NUM_PORTS*WIDTH_BRM-1:0] i_issue_brm,
    input  logic [NUM_BRM-1:0]             i_brkill,
    output logic [NUM_PORTS*WIDTH_REG-1:0] o_WDest4x,
    output logic [NUM_PORTS*MAX_LAT-1:0]   o_busy,
    output logic [NUM_PORTS-1:0]           o_conflict
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
        wakeup_lane u_lane (
            .clk      (i_clk),
            .rst      (i_rst),
            .val      (i_issue_val[p]),
            .rd       (get_rd(i_issue_rd, p)),
            .lat      (get_lat(i_issue_lat, p)),
            .brm      (get_brm(i_issue_brm, p)),
            .brkill   (i_brkill),
            .wdest    (o_WDest4x[p*WIDTH_REG +: WIDTH_REG]),
            .busy     (o_busy[p*MAX_LAT +: MAX_LAT]),
            .conflict (o_conflict[p])
        );
    end

endmodule

// File: tb/tb_wakeup_bcast.sv
// Bench for wakeup_bcast: due-cycle scoreboard model checked every cycle plus directed literal checks.
module tb_wakeup_bcast;
    import wakeup_bcast_pkg::*;

    logic                           i_clk = 1'b0;
    logic                           i_rst;
    logic [NUM_PORTS-1:0]           i_issue_val;
    logic [NUM_PORTS*WIDTH_REG-1:0] i_issue_rd;
    logic [NUM_PORTS*WIDTH_LAT-1:0] i_issue_lat;
    logic [NUM_PORTS*WIDTH_BRM-1:0] i_issue_brm;
    logic [NUM_BRM-1:0]             i_brkill;
    logic [NUM_PORTS*WIDTH_REG-1:0] o_WDest4x;
    logic [NUM_PORTS*MAX_LAT-1:0]   o_busy;
    logic [NUM_PORTS-1:0]           o_conflict;

    wakeup_bcast dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_issue_val (i_issue_val),
        .i_issue_rd  (i_issue_rd),
        .i_issue_lat (i_issue_lat),
        .i_issue_brm (i_issue_brm),
        .i_brkill    (i_brkill),
        .o_WDest4x   (o_WDest4x),
        .o_busy      (o_busy),
        .o_conflict  (o_conflict)
    );

    always #5 i_clk = ~i_clk;

    // Model: every live op is a record of the cycle in which its tag must appear.
    typedef struct {
        int                   port;
        int                   due;
        logic [WIDTH_REG-1:0] rd;
        logic [WIDTH_BRM-1:0] brm;
    } op_t;

    op_t                            pend[$];
    logic [NUM_PORTS-1:0]           exp_conf;
    logic [NUM_PORTS*WIDTH_REG-1:0] exp_w;
    logic [NUM_PORTS*MAX_LAT-1:0]   exp_b;
    int                             cyc = 0;
    int                             n_pass = 0;
    int                             n_total = 0;
    bit                             chk_en = 1'b0;
    int                             m_due;
    bit                             m_hit;
    logic [WIDTH_REG-1:0]           m_rd;
    logic [WIDTH_BRM-1:0]           m_brm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp_v);
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend.delete();
            exp_conf = '0;
        end else begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due <= cyc || i_brkill[pend[i].brm]) pend.delete(i);
            end
            exp_conf = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                m_rd  = i_issue_rd[p*WIDTH_REG +: WIDTH_REG];
                m_brm = i_issue_brm[p*WIDTH_BRM +: WIDTH_BRM];
                if (i_issue_val[p] && m_rd != 0) begin
                    m_due = cyc + int'(i_issue_lat[p*WIDTH_LAT +: WIDTH_LAT]) + 1;
                    m_hit = 1'b0;
                    foreach (pend[i]) if (pend[i].port == p && pend[i].due == m_due) m_hit = 1'b1;
                    if (m_hit) exp_conf[p] = 1'b1;
                    else if (!i_brkill[m_brm]) pend.push_back('{p, m_due, m_rd, m_brm});
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            exp_w = '0;
            exp_b = '0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc) exp_w[pend[i].port*WIDTH_REG +: WIDTH_REG] = pend[i].rd;
                for (int k = 0; k < MAX_LAT; k++)
                    if (pend[i].due == cyc + k + 1) exp_b[pend[i].port*MAX_LAT + k] = 1'b1;
            end
            chk("model_wdest", 64'(o_WDest4x), 64'(exp_w));
            chk("model_busy", 64'(o_busy), 64'(exp_b));
            chk("model_conflict", 64'(o_conflict), 64'(exp_conf));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_clk);
    endtask

    task automatic clr();
        i_issue_val = '0;
        i_issue_rd  = '0;
        i_issue_lat = '0;
        i_issue_brm = '0;
        i_brkill    = '0;
    endtask

    task automatic set_issue(input int p, input int rd, input int l, input int b);
        i_issue_val[p] = 1'b1;
        i_issue_rd[p*WIDTH_REG +: WIDTH_REG]  = rd[WIDTH_REG-1:0];
        i_issue_lat[p*WIDTH_LAT +: WIDTH_LAT] = WIDTH_LAT'(l - 1);
        i_issue_brm[p*WIDTH_BRM +: WIDTH_BRM] = b[WIDTH_BRM-1:0];
    endtask

    initial begin
        clr();
        i_rst = 1'b1;
        repeat (3) tick();
        i_rst  = 1'b0;
        chk_en = 1'b1;
        at_neg();
        chk("reset_wdest", 64'(o_WDest4x), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_conflict", 64'(o_conflict), 64'd0);
        repeat (10) tick();

        // reset asserted while an L=4 op is in flight
        set_issue(2, 7, 4, 0);
        tick(); clr();
        tick();
        i_rst = 1'b1;
        at_neg();
        chk("rst_mid_busy", 64'(o_busy), 64'd0);
        tick();
        i_rst = 1'b0;
        tick(); at_neg();
        chk("rst_mid_gone", 64'(o_WDest4x), 64'd0);
        repeat (3) tick();

        for (int l = 1; l <= MAX_LAT; l++) begin
            set_issue(2, 7, l, 0);
            tick(); clr();
            repeat (l - 1) tick();
            at_neg();
            chk("lat_sweep_hit", 64'(o_WDest4x), 64'd7 << (2*WIDTH_REG));
            tick(); at_neg();
            chk("lat_sweep_once", 64'(o_WDest4x), 64'd0);
            repeat (2) tick();
        end

        set_issue(0, 3, 3, 0); tick(); clr();
        set_issue(0, 4, 3, 0); tick(); clr();
        set_issue(0, 5, 3, 0); tick(); clr();
        at_neg(); chk("b2b_rd3", 64'(o_WDest4x), 64'd3);
        tick(); at_neg(); chk("b2b_rd4", 64'(o_WDest4x), 64'd4);
        chk("b2b_conflict", 64'(o_conflict), 64'd0);
        tick(); at_neg(); chk("b2b_rd5", 64'(o_WDest4x), 64'd5);
        repeat (3) tick();

        set_issue(1, 9, 3, 0); tick(); clr();
        set_issue(1, 10, 2, 0);
        at_neg(); chk("coll_busy", 64'(o_busy[1*MAX_LAT+1]), 64'd1);
        tick(); clr();
        at_neg(); chk("coll_conflict", 64'(o_conflict), 64'b0010);
        tick(); at_neg(); chk("coll_winner", 64'(o_WDest4x), 64'd9 << WIDTH_REG);
        tick(); at_neg(); chk("coll_dropped", 64'(o_WDest4x), 64'd0);
        repeat (3) tick();

        // older entry killed on the collision edge gives way to the new issue
        set_issue(1, 9, 3, 2); tick(); clr();
        set_issue(1, 10, 2, 0);
        i_brkill = 8'h04;
        tick(); clr();
        at_neg(); chk("killold_conflict", 64'(o_conflict), 64'd0);
        tick(); at_neg(); chk("killold_new", 64'(o_WDest4x), 64'd10 << WIDTH_REG);
        repeat (3) tick();

        set_issue(3, 12, 4, 5); tick(); clr();
        tick();
        i_brkill = 8'b0010_0000;
        tick(); clr();
        tick(); at_neg(); chk("kill_inflight", 64'(o_WDest4x), 64'd0);
        repeat (3) tick();

        set_issue(3, 12, 4, 5);
        i_brkill = 8'b0010_0000;
        tick(); clr();
        at_neg(); chk("kill_same_busy", 64'(o_busy), 64'd0);
        repeat (3) tick();
        at_neg(); chk("kill_same", 64'(o_WDest4x), 64'd0);
        repeat (3) tick();

        set_issue(3, 12, 4, 5); tick(); clr();
        tick();
        i_brkill = 8'b0001_0000;
        tick(); clr();
        tick(); at_neg(); chk("kill_nomatch", 64'(o_WDest4x), 64'd12 << (3*WIDTH_REG));
        repeat (3) tick();

        set_issue(0, 0, 1, 0);
        set_issue(1, 6, 1, 0);
        set_issue(2, 6, 1, 0);
        set_issue(3, 31, 1, 0);
        tick(); clr();
        at_neg(); chk("multi_lanes", 64'(o_WDest4x), 64'({5'd31, 5'd6, 5'd6, 5'd0}));
        chk("multi_conflict", 64'(o_conflict), 64'd0);
        tick(); at_neg(); chk("multi_once", 64'(o_WDest4x), 64'd0);
        repeat (4) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
